eprom_wr_seq: RTL

EPROM_WR_SEQ -- requirements
Module: eprom_wr_seq

---
 rtl/eprom_wr_seq_pkg.sv | 20 ++
 rtl/eprom_req_fifo.sv | 72 +++++++
 rtl/eprom_wr_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/eprom_wr_seq_pkg.sv
// Shared definitions for the EPROM write sequencer: state encoding, defaults and request record.
package eprom_wr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_e;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 31;
    localparam int REQ_W           = 16;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

endpackage

// File: rtl/eprom_req_fifo.sv
// Request FIFO: DEPTH entries of {addr,data}, power-of-two depth so pointers wrap naturally.
module eprom_req_fifo
    import eprom_wr_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [REQ_W-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [REQ_W-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [REQ_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (level_q == LW'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even if the same cycle pops.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/eprom_wr_seq.sv
// EPROM write sequencer: buffers requests and hands them one at a time to the serial eprom writer,
// with a one-cycle start pulse, ack timeout and a one-cycle gap between transactions.
module eprom_wr_seq
    import eprom_wr_seq_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_addr,
    input  logic [7:0]               req_data,
    output logic                     write_ctrl,
    output logic [7:0]               address,
    output logic [7:0]               data,
    input  logic                     ack,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    seq_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wc_q, wc_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    req_t             head;
    req_t             push_rec;

    assign push_rec = '{addr: req_addr, data: req_data};

    eprom_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_valid),
        .push_data_i (push_rec),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    assign req_ready   = !fifo_full;
    assign write_ctrl  = wc_q;
    assign address     = addr_q;
    assign data        = data_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    addr_d  = head.addr;
                    data_d  = head.data;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // ack takes priority so an ack on the last allowed cycle is a success.
                if (ack) begin
                    state_d = ST_GAP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        wc_d   = (state_q == ST_START);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wc_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

endmodule
